// File: rtl/dtg_pkg.sv
// Shared timing constants, counter width and the registered pixel-state struct
// for the display timing generator.
package dtg_pkg;

  localparam int CNT_W = 12;
  localparam int FC_W  = 16;

  localparam int DTG_H_ACTIVE = 1024;
  localparam int DTG_H_FRONT  = 24;
  localparam int DTG_H_SYNC   = 136;
  localparam int DTG_H_BACK   = 144;
  localparam int DTG_V_ACTIVE = 768;
  localparam int DTG_V_FRONT  = 3;
  localparam int DTG_V_SYNC   = 6;
  localparam int DTG_V_BACK   = 29;

  localparam int DTG_H_TOTAL = DTG_H_ACTIVE + DTG_H_FRONT + DTG_H_SYNC + DTG_H_BACK;
  localparam int DTG_V_TOTAL = DTG_V_ACTIVE + DTG_V_FRONT + DTG_V_SYNC + DTG_V_BACK;

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             von;
    logic             fs;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
  } dtg_pix_t;

  // True when lo <= c < lo+len.
  function automatic logic in_win(logic [CNT_W-1:0] c, int lo, int len);
    return (int'(c) >= lo) && (int'(c) < lo + len);
  endfunction

endpackage

// File: rtl/dtg_if.sv
// Video timing bundle from the generator to the VGA/colorizer stage.
// frame_count exists only when DTG_FRAME_COUNT_EN is defined.
interface dtg_if;
  import dtg_pkg::*;

  logic             horiz_sync;
  logic             vert_sync;
  logic             video_on;
  logic             frame_start;
  logic [CNT_W-1:0] pixel_column;
  logic [CNT_W-1:0] pixel_row;
`ifdef DTG_FRAME_COUNT_EN
  logic [FC_W-1:0]  frame_count;
`endif

  modport master (
    output horiz_sync, vert_sync, video_on, frame_start, pixel_column, pixel_row
`ifdef DTG_FRAME_COUNT_EN
    , output frame_count
`endif
  );

  modport slave (
    input horiz_sync, vert_sync, video_on, frame_start, pixel_column, pixel_row
`ifdef DTG_FRAME_COUNT_EN
    , input frame_count
`endif
  );

endinterface

// File: rtl/dtg_wrap_counter.sv
// Enabled up-counter that wraps from MAX to 0; wrap flags the enabled MAX cycle.
module dtg_wrap_counter #(
  parameter int MAX = 1327,
  parameter int W   = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(MAX));

  always_ff @(posedge clk) begin
    if (reset)   count <= '0;
    else if (en) count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/display_timing_gen.sv
// Pixel-clock video timing generator: h/v counters, decode and output registers.
// Optional frame counter output enabled by defining DTG_FRAME_COUNT_EN.
module display_timing_gen
  import dtg_pkg::*;
#(
  parameter int   H_ACTIVE    = DTG_H_ACTIVE,
  parameter int   H_FRONT     = DTG_H_FRONT,
  parameter int   H_SYNC      = DTG_H_SYNC,
  parameter int   H_BACK      = DTG_H_BACK,
  parameter int   V_ACTIVE    = DTG_V_ACTIVE,
  parameter int   V_FRONT     = DTG_V_FRONT,
  parameter int   V_SYNC      = DTG_V_SYNC,
  parameter int   V_BACK      = DTG_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic   clk,
  input  logic   reset,
  dtg_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap_unused;
  dtg_pix_t         pix_d, pix_q;

  dtg_wrap_counter #(.MAX(H_TOTAL-1), .W(CNT_W)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  dtg_wrap_counter #(.MAX(V_TOTAL-1), .W(CNT_W)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap_unused)
  );

  // Decode of the current counters; registered below so outputs lag by one clock.
  always_comb begin
    pix_d     = '0;
    pix_d.col = h_cnt;
    pix_d.row = v_cnt;
    pix_d.von = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    pix_d.hs  = in_win(h_cnt, H_ACTIVE + H_FRONT, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    pix_d.vs  = in_win(v_cnt, V_ACTIVE + V_FRONT, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    pix_d.fs  = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q.hs  <= ~SYNC_ACTIVE;
      pix_q.vs  <= ~SYNC_ACTIVE;
      pix_q.von <= 1'b0;
      pix_q.fs  <= 1'b0;
      pix_q.col <= '0;
      pix_q.row <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign vid.horiz_sync   = pix_q.hs;
  assign vid.vert_sync    = pix_q.vs;
  assign vid.video_on     = pix_q.von;
  assign vid.frame_start  = pix_q.fs;
  assign vid.pixel_column = pix_q.col;
  assign vid.pixel_row    = pix_q.row;

`ifdef DTG_FRAME_COUNT_EN
  logic [FC_W-1:0] frame_cnt;

  // Bumps on the edge that raises frame_start; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset)         frame_cnt <= '0;
    else if (pix_d.fs) frame_cnt <= frame_cnt + 1'b1;
  end

  assign vid.frame_count = frame_cnt;
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Scoreboard bench: default-timing instance for line checks, reduced-timing
// instance for full-frame, mid-frame reset and frame-count checks.
module tb_display_timing_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dtg_if vid_a ();
  dtg_if vid_b ();

  display_timing_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vid   (vid_a)
  );

  // Small timing: H 16+2+4+3 = 25, V 8+1+2+2 = 13, frame = 325 clocks.
  display_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vid   (vid_b)
  );

  localparam int A = 0;
  localparam int B = 6;
  localparam int S_COL = 0, S_ROW = 1, S_VON = 2, S_HS = 3, S_VS = 4, S_FS = 5;
  localparam int B_FC = 12, A_HSLOW = 13, B_VSLOW = 14, B_GAP = 15, B_VONBAD = 16;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;
  int a_hs_low = 0, b_vs_low = 0, b_von_bad = 0;
  int b_fs1 = -1, b_fs2 = -1;

  function automatic string sel_name(int sel);
    case (sel)
      A+S_COL: return "a_col";   A+S_ROW: return "a_row";   A+S_VON: return "a_video_on";
      A+S_HS:  return "a_hsync"; A+S_VS:  return "a_vsync"; A+S_FS:  return "a_frame_start";
      B+S_COL: return "b_col";   B+S_ROW: return "b_row";   B+S_VON: return "b_video_on";
      B+S_HS:  return "b_hsync"; B+S_VS:  return "b_vsync"; B+S_FS:  return "b_frame_start";
      B_FC:     return "b_frame_count";
      A_HSLOW:  return "a_hsync_low_cycles";
      B_VSLOW:  return "b_vsync_low_cycles";
      B_GAP:    return "b_frame_start_gap";
      B_VONBAD: return "b_video_on_in_blank";
      default:  return "unknown";
    endcase
  endfunction

  function automatic logic [15:0] act(int sel);
    case (sel)
      A+S_COL: return 16'(vid_a.pixel_column);
      A+S_ROW: return 16'(vid_a.pixel_row);
      A+S_VON: return {15'b0, vid_a.video_on};
      A+S_HS:  return {15'b0, vid_a.horiz_sync};
      A+S_VS:  return {15'b0, vid_a.vert_sync};
      A+S_FS:  return {15'b0, vid_a.frame_start};
      B+S_COL: return 16'(vid_b.pixel_column);
      B+S_ROW: return 16'(vid_b.pixel_row);
      B+S_VON: return {15'b0, vid_b.video_on};
      B+S_HS:  return {15'b0, vid_b.horiz_sync};
      B+S_VS:  return {15'b0, vid_b.vert_sync};
      B+S_FS:  return {15'b0, vid_b.frame_start};
`ifdef DTG_FRAME_COUNT_EN
      B_FC:    return vid_b.frame_count;
`endif
      A_HSLOW:  return 16'(a_hs_low);
      B_VSLOW:  return 16'(b_vs_low);
      B_GAP:    return 16'(b_fs2 - b_fs1);
      B_VONBAD: return 16'(b_von_bad);
      default:  return 16'hDEAD;
    endcase
  endfunction

  task automatic push(int c, int sel, logic [15:0] e);
    exp_t x;
    x.cyc = c; x.sel = sel; x.exp = e;
    q.push_back(x);
  endtask

  task automatic px(int c, int base, int col, int row, logic von, logic fs);
    push(c, base+S_COL, 16'(col));
    push(c, base+S_ROW, 16'(row));
    push(c, base+S_VON, {15'b0, von});
    push(c, base+S_FS,  {15'b0, fs});
  endtask

  task automatic sync(int c, int base, logic hs, logic vs);
    push(c, base+S_HS, {15'b0, hs});
    push(c, base+S_VS, {15'b0, vs});
  endtask

  task automatic rst_vals(int c, int base);
    px(c, base, 0, 0, 1'b0, 1'b0);
    sync(c, base, 1'b1, 1'b1);
  endtask

  task automatic wait_cyc(int n);
    while (cyc != n) @(negedge clk);
  endtask

  // Monitor: outputs are valid every clock; sampled on the falling edge.
  always @(negedge clk) begin
    if (cyc >= 6 && cyc <= 1333 && vid_a.horiz_sync == 1'b0) a_hs_low++;
    if (cyc >= 6 && cyc <= 330 && vid_b.vert_sync == 1'b0) b_vs_low++;
    if (vid_b.frame_start) begin
      if (b_fs1 < 0) b_fs1 = cyc;
      else if (b_fs2 < 0) b_fs2 = cyc;
    end
    if (vid_b.video_on && (vid_b.pixel_row >= 12'd8 || vid_b.pixel_column >= 12'd16)) b_von_bad++;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        logic [15:0] a;
        a = act(q[i].sel);
        checks++;
        if (a === q[i].exp) passes++;
        else $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h",
                      sel_name(q[i].sel), cyc, a, q[i].exp);
        q.delete(i);
      end
    end
  end

  initial begin
    // Default timing: reset, first edges, one full line.
    rst_vals(3, A); rst_vals(5, A);
    px(6, A, 0, 0, 1'b1, 1'b1); sync(6, A, 1'b1, 1'b1);
    px(7, A, 1, 0, 1'b1, 1'b0);
    px(6+1023, A, 1023, 0, 1'b1, 1'b0);
    px(6+1024, A, 1024, 0, 1'b0, 1'b0);
    sync(6+1047, A, 1'b1, 1'b1); sync(6+1048, A, 1'b0, 1'b1);
    sync(6+1183, A, 1'b0, 1'b1); sync(6+1184, A, 1'b1, 1'b1);
    px(6+1327, A, 1327, 0, 1'b0, 1'b0);
    px(6+1328, A, 0, 1, 1'b1, 1'b0);
    push(1334, A_HSLOW, 16'd136);

    // Small timing: line, frame, vsync window, frame period.
    rst_vals(5, B);
    px(6, B, 0, 0, 1'b1, 1'b1);
    px(6+15, B, 15, 0, 1'b1, 1'b0); px(6+16, B, 16, 0, 1'b0, 1'b0);
    sync(6+17, B, 1'b1, 1'b1); sync(6+18, B, 1'b0, 1'b1);
    sync(6+21, B, 1'b0, 1'b1); sync(6+22, B, 1'b1, 1'b1);
    px(6+24, B, 24, 0, 1'b0, 1'b0); px(6+25, B, 0, 1, 1'b1, 1'b0);
    px(196, B, 15, 7, 1'b1, 1'b0);
    px(206, B, 0, 8, 1'b0, 1'b0); sync(206, B, 1'b1, 1'b1);
    sync(230, B, 1'b1, 1'b1); sync(231, B, 1'b1, 1'b0);
    sync(249, B, 1'b0, 1'b0);
    sync(280, B, 1'b1, 1'b0); sync(281, B, 1'b1, 1'b1);
    px(330, B, 24, 12, 1'b0, 1'b0); px(331, B, 0, 0, 1'b1, 1'b1);
    push(331, B_VSLOW, 16'd50);
    push(340, B_GAP, 16'd325);

    // Mid-frame reset at row 5 col 10, then reset on the line-wrap edge.
    px(466, B, 10, 5, 1'b1, 1'b0);
    rst_vals(467, B);
    px(468, B, 0, 0, 1'b1, 1'b1); px(469, B, 1, 0, 1'b1, 1'b0);
    px(491, B, 23, 0, 1'b0, 1'b0);
    rst_vals(492, B);
    px(493, B, 0, 0, 1'b1, 1'b1); px(494, B, 1, 0, 1'b1, 1'b0);
    px(818, B, 0, 0, 1'b1, 1'b1);
    push(1499, B_VONBAD, 16'd0);

`ifdef DTG_FRAME_COUNT_EN
    push(5, B_FC, 16'd0);   push(6, B_FC, 16'd1);   push(330, B_FC, 16'd1);
    push(331, B_FC, 16'd2); push(467, B_FC, 16'd0); push(468, B_FC, 16'd1);
    push(492, B_FC, 16'd0); push(493, B_FC, 16'd1); push(818, B_FC, 16'd2);
    push(1143, B_FC, 16'd3);
    push(1300, B_FC, 16'hFFFF); push(1467, B_FC, 16'hFFFF); push(1468, B_FC, 16'h0000);
`endif

    wait_cyc(5);
    rst_a = 1'b0;
    rst_b = 1'b0;
    wait_cyc(466); rst_b = 1'b1;
    wait_cyc(467); rst_b = 1'b0;
    wait_cyc(491); rst_b = 1'b1;
    wait_cyc(492); rst_b = 1'b0;
`ifdef DTG_FRAME_COUNT_EN
    wait_cyc(1200); force dut_b.frame_cnt = 16'hFFFF;
    wait_cyc(1201); release dut_b.frame_cnt;
`endif
    wait_cyc(1500);
    @(negedge clk);
    foreach (q[i]) begin
      checks++;
      $display("FAIL %s @cyc %0d: never sampled, expected 0x%0h",
               sel_name(q[i].sel), q[i].cyc, q[i].exp);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
